// File: rtl/bp_be_fe_resolve.sv
// bp_be_fe_resolve: BE commit-point branch resolution producing FE redirects and attaboys
//
// Compares each retiring instruction's actual next PC with the PC the frontend
// fetched after it.
// - A mispredict becomes a one-cycle, valid-only redirect.
// - A correctly predicted branch or jump becomes a buffered valid/yumi attaboy.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   resolve_*               resolving instruction (valid/ready handshake)
//   redirect_*              registered redirect to FE (no handshake)
//   attaboy_*               attaboy FIFO head (valid/yumi, combinational data)
//   stat_*_o                saturating counters, present only with BP_BE_FE_RESOLVE_STATS_EN
//
// Branch metadata layout (low bits):
//   [0] is_br  [1] is_jal  [2] is_jalr  [3] src_btb  [MSB:4] ghist / table indices
module bp_be_fe_resolve
  #(parameter int bp_params_p = 0
   ,parameter int attaboy_els_p = 4
   ,localparam int vaddr_width_p = (bp_params_p == 0) ? 39 : 48
   ,localparam int branch_metadata_fwd_width_p = (bp_params_p == 0) ? 36 : 48
   )
   (input  logic                                   clk_i
   ,input  logic                                   reset_n_i
   ,input  logic                                   resolve_v_i
   ,output logic                                   resolve_ready_o
   ,input  logic [vaddr_width_p-1:0]               resolve_pc_i
   ,input  logic [vaddr_width_p-1:0]               resolve_npc_i
   ,input  logic [vaddr_width_p-1:0]               resolve_pred_npc_i
   ,input  logic                                   resolve_taken_i
   ,input  logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_i
   ,output logic                                   redirect_v_o
   ,output logic [vaddr_width_p-1:0]               redirect_pc_o
   ,output logic                                   redirect_br_taken_o
   ,output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_o
   ,output logic                                   attaboy_v_o
   ,output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_o
`ifdef BP_BE_FE_RESOLVE_STATS_EN
   ,output logic [31:0]                            stat_mispredict_o
   ,output logic [31:0]                            stat_attaboy_o
   ,output logic [31:0]                            stat_drop_o
`endif
   ,input  logic                                   attaboy_yumi_i
   );

    localparam int pw = $clog2(attaboy_els_p);
    localparam logic [0:0] e_run  = 1'b0;
    localparam logic [0:0] e_wait = 1'b1;

    logic [0:0]                             state_r;
    logic [vaddr_width_p-1:0]               target_r;
    logic [branch_metadata_fwd_width_p-1:0] mem_r [attaboy_els_p];
    logic [pw:0]                            wptr_r, rptr_r;
    logic full, empty, accept, on_path, classify, mispredict, is_ctl, push, pop, drop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wptr_r[pw-1:0] == rptr_r[pw-1:0]) && (wptr_r[pw] != rptr_r[pw]);
    assign empty = (wptr_r == rptr_r);

    assign resolve_ready_o = ~full;
    assign accept     = resolve_v_i & ~full;
    // While waiting, only the instruction at the redirect target is on the correct path.
    assign on_path    = (state_r == e_run) || (resolve_pc_i == target_r);
    assign classify   = accept & on_path;
    assign drop       = accept & ~on_path;
    assign mispredict = classify & (resolve_npc_i != resolve_pred_npc_i);
    assign is_ctl     = |resolve_br_metadata_i[2:0];
    assign push       = classify & ~mispredict & is_ctl;
    // A redirect owns the shared BHT write port, so the head attaboy is held back.
    assign attaboy_v_o = ~empty & ~redirect_v_o;
    assign pop         = attaboy_yumi_i & attaboy_v_o;
    assign attaboy_br_metadata_o = empty ? '0 : mem_r[rptr_r[pw-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r                <= e_run;
            target_r               <= '0;
            wptr_r                 <= '0;
            rptr_r                 <= '0;
            redirect_v_o           <= 1'b0;
            redirect_pc_o          <= '0;
            redirect_br_taken_o    <= 1'b0;
            redirect_br_metadata_o <= '0;
        end else begin
            state_r      <= classify ? (mispredict ? e_wait : e_run) : state_r;
            target_r     <= mispredict ? resolve_npc_i : target_r;
            wptr_r       <= wptr_r + (pw+1)'(push);
            rptr_r       <= rptr_r + (pw+1)'(pop);
            redirect_v_o <= mispredict;
            if (mispredict) begin
                redirect_pc_o          <= resolve_npc_i;
                redirect_br_taken_o    <= resolve_taken_i;
                redirect_br_metadata_o <= resolve_br_metadata_i;
            end
        end
    end

    // Storage needs no reset; entries are only visible between push and pop.
    always_ff @(posedge clk_i) begin
        if (push)
            mem_r[wptr_r[pw-1:0]] <= resolve_br_metadata_i;
    end

`ifdef BP_BE_FE_RESOLVE_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_mispredict_o <= '0;
            stat_attaboy_o    <= '0;
            stat_drop_o       <= '0;
        end else begin
            stat_mispredict_o <= stat_mispredict_o + 32'(mispredict && (stat_mispredict_o != '1));
            stat_attaboy_o    <= stat_attaboy_o    + 32'(pop        && (stat_attaboy_o    != '1));
            stat_drop_o       <= stat_drop_o       + 32'(drop       && (stat_drop_o       != '1));
        end
    end
`endif

endmodule

// File: doc/bp_be_fe_resolve.md
# bp_be_fe_resolve

Backend-side branch resolution block: the producer end of the FE redirect/attaboy interface that FE PC generation consumes. It sits at the BE commit point and compares each retiring instruction's actual next PC with the PC the frontend fetched after it. Mispredictions become single-cycle, valid-only redirects. Correct branch/jump predictions become buffered valid-yumi attaboys that train the BHT/BTB.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_default_cfg`: source of `vaddr_width_p` and `branch_metadata_fwd_width_p`.
- `attaboy_els_p`, default 4: attaboy FIFO depth; power of two, ≥2.

Ports:
- `clk_i` in, 1: single clock.
- `reset_n_i` in, 1: asynchronous, active-low reset.
- `resolve_v_i` in, 1: a resolving instruction is valid this cycle.
- `resolve_ready_o` out, 1: resolution accepted when `resolve_v_i & resolve_ready_o`.
- `resolve_pc_i` in, `vaddr_width_p`: PC of the resolving instruction.
- `resolve_npc_i` in, `vaddr_width_p`: architecturally correct next PC.
- `resolve_pred_npc_i` in, `vaddr_width_p`: PC the frontend fetched next.
- `resolve_taken_i` in, 1: control transfer actually taken.
- `resolve_br_metadata_i` in, `branch_metadata_fwd_width_p`: FE branch metadata (`is_br`/`is_jal`/`is_jalr`/`src_btb`/`ghist`/indices).
- `redirect_v_o` out, 1: valid-only redirect to FE.
- `redirect_pc_o` out, `vaddr_width_p`: corrected PC.
- `redirect_br_taken_o` out, 1: actual taken outcome.
- `redirect_br_metadata_o` out, `branch_metadata_fwd_width_p`: metadata of the mispredicted instruction.
- `attaboy_v_o` out, 1: attaboy available.
- `attaboy_br_metadata_o` out, `branch_metadata_fwd_width_p`: metadata of the correctly predicted instruction.
- `attaboy_yumi_i` in, 1: FE consumes the head attaboy.

## Operation
- Accepted resolutions are classified as follows:
  - Mispredict: `resolve_npc_i != resolve_pred_npc_i`, for any instruction type, including non-branches with a stale BTB hit.
  - Correct control: no mispredict and (`is_br|is_jal|is_jalr`).
  - Correct plain: anything else. No action.
- Mispredict: register a redirect with `redirect_pc_o=resolve_npc_i`, `redirect_br_taken_o=resolve_taken_i` and the metadata. Latch target = `resolve_npc_i`. Go to `e_wait`.
- Correct control: push the metadata into the attaboy FIFO.
- FSM states:
  - `e_run`: all accepted resolutions are classified.
  - `e_wait`: wrong-path resolutions (`resolve_pc_i != target`) are accepted and dropped. A resolution with `resolve_pc_i == target` is classified normally and returns the FSM to `e_run`. If that resolution is itself a mispredict, the FSM re-latches the target and stays in `e_wait`.
- `resolve_ready_o = ~fifo_full` in both states. Drops and redirects also obey it.
- Attaboy FIFO: circular, with `$clog2(attaboy_els_p)+1`-bit read and write pointers. Full when the low bits are equal and the MSBs differ; empty when the pointers are equal. Pointers wrap modulo 2·depth.
- Simultaneous push and pop while full: the pop happens, and the push is blocked because ready was low.
- Reset values: `redirect_v_o=0`, `attaboy_v_o=0`, `resolve_ready_o=1`. All data outputs are 0, the FIFO is empty and the FSM is in `e_run`. Reset asserted mid-operation clears everything immediately; queued attaboys are lost.

## Timing
- Accepted mispredict in cycle t → `redirect_v_o=1` in cycle t+1 only. FE must act on it, because there is no handshake.
- Back-to-back mispredicts (t, t+1) → redirects in t+1 and t+2.
- Attaboy pushed at t → earliest `attaboy_v_o` at t+1.
- `attaboy_v_o` is forced to 0 in any cycle where `redirect_v_o=1`, because FE gives redirect priority on the shared BHT write port. The head entry is held and reappears the next cycle.
- `attaboy_yumi_i` is legal only when `attaboy_v_o=1`. It pops in the same cycle and the next entry is presented at the following cycle.
- FIFO output is combinational from the head entry; all other outputs are registered.

## Configuration
- `BP_BE_FE_RESOLVE_STATS_EN` defined adds three 32-bit saturating output counters:
  - `stat_mispredict_o`: mispredicts.
  - `stat_attaboy_o`: attaboys popped.
  - `stat_drop_o`: wrong-path resolutions dropped.
- All three counters reset to 0 and hold at `32'hFFFF_FFFF`.
- Undefined: these ports and registers do not exist; functional behaviour is identical.

## Test plan
- Correct `is_br` at PC `0x8000_0000`, npc=pred=`0x8000_0004`: `attaboy_v_o` rises next cycle with the same metadata. Yumi → FIFO empty, no redirect.
- Mispredict at PC `0x100` with npc `0x200` and pred `0x104`: `redirect_v_o` is high for exactly one cycle with `redirect_pc_o=0x200`. Resolutions at `0x104`/`0x108` are dropped. Resolution at `0x200` returns the FSM to `e_run`.
- Hold `attaboy_yumi_i=0` and send 5 correct branches: `resolve_ready_o` falls after the 4th. One yumi → ready rises, and the 5th is accepted and ends up at the FIFO tail.
- Attaboy pending with a mispredict accepted the same cycle: in the redirect cycle `attaboy_v_o=0`; the attaboy reappears the following cycle.
- Assert `reset_n_i` low mid-`e_wait` with 3 queued attaboys: outputs clear asynchronously. After release, a resolution at any PC is classified (`e_run`).
- With `BP_BE_FE_RESOLVE_STATS_EN` defined, run scenario 2: `stat_mispredict_o=1`, `stat_drop_o=2`.
